mem_responder: RTL and testbench
================================

# mem_responder

Synchronous SRAM responder serving the zzcpu pipeline's memory requests. It accepts single read/write requests from the IF or MEM stage over a valid/ready handshake and drives the board's asynchronous SRAM pins (Ram1 or Ram2 bank) with registered, glitch-free OE/WE/EN timing. It returns read data, or a write acknowledge, as a one-cycle response pulse. One instance is placed per SRAM bank, between the pipeline stage and the external pins.

## Interface
- WAIT_CYCLES, 1: cycles OE or WE is held low per access (≥1)
- ADDR_W, 18: SRAM address width
- DATA_W, 16: SRAM data width

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  reset; **synchronous, active-high**
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse: read data valid / write done
- rsp_rdata  out  DATA_W  captured read data, held until next read completes
- SramAddr  out  ADDR_W  to RamxAddr
- SramData  inout  DATA_W  to RamxData
- SramOE  out  1  active-low output enable
- SramWE  out  1  active-low write enable
- SramEN  out  1  active-low chip enable

## Operation
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: req_ready=1. On req_valid, latch addr/we/wdata. Go to RD if we=0, otherwise go to WR_SETUP.
- RD: EN=0, OE=0, WE=1, data bus Z, for WAIT_CYCLES cycles. On the final cycle's edge, capture SramData into rsp_rdata, pulse rsp_valid, and return to IDLE.
- WR_SETUP (1 cycle): EN=0, OE=1, WE=1, bus driven with latched wdata.
- WR_PULSE: WE=0 for WAIT_CYCLES cycles, bus driven.
- WR_HOLD (1 cycle): WE=1, bus still driven. On exit, pulse rsp_valid and return to IDLE. rsp_rdata is unchanged.
- The bus is driven only in WR_* states. OE=0 and bus-driven never coincide.
- All pin outputs are registered, with no combinational path from req_* to the pins.
- Request fields are ignored when req_ready=0. Requests are never queued.
- Wait counter is $clog2(WAIT_CYCLES+1) bits, loaded on state entry and decremented to 0.

## Timing
- Reset values (the cycle after rst is sampled high):
  - Idle state: req_ready=1, rsp_valid=0, rsp_rdata=0.
  - Pins: SramAddr=0, OE=1, WE=1, EN=1, data bus Z.
- Read latency: request accepted at edge 0, rsp_valid high in cycle WAIT_CYCLES+1.
- Write latency: rsp_valid high in cycle WAIT_CYCLES+3.
- rsp_valid and req_ready are both high in the response cycle, so back-to-back accepts are legal. IDLE provides one bus turnaround cycle between any two accesses.
- Reset mid-access: abort the access.
  - OE, WE and EN return to 1 and the bus goes to Z on the reset edge.
  - No rsp_valid is issued.

## Configuration
- MEM_RESP_STATS_EN defined: adds outputs rd_count and wr_count (each 16 bits).
  - Each counter increments on its rsp_valid and wraps 0xFFFF→0.
  - Both clear on rst.
- MEM_RESP_STATS_EN undefined: those ports and registers do not exist.

## Structure
- Shared package holds:
  - State enum: MR_IDLE, MR_RD, MR_WR_SETUP, MR_WR_PULSE, MR_WR_HOLD.
  - Constant SRAM_INACTIVE = 1'b1.
- No sub-module is needed. The tristate is an inline assign on SramData, gated by a registered drive_en.

## Test plan
- Reset: hold rst 2 cycles → EN/OE/WE=1, bus Z, rsp_valid=0, req_ready=1 on the first cycle after release.
- Write 0x1234 to 0x00010, WAIT_CYCLES=1 → WE low exactly 1 cycle, bus=0x1234 from WR_SETUP through WR_HOLD, rsp_valid in cycle 4.
- Read 0x00010, SRAM model returns 0x1234 → OE low exactly 1 cycle, rsp_rdata=0x1234 with rsp_valid in cycle 2. Repeat with WAIT_CYCLES=3 → OE low 3 cycles, response in cycle 4.
- Read immediately followed by write to 0x3FFFF with data 0xFFFF → second request accepted in the read's response cycle; no cycle has OE=0 while the bus is driven.
- Assert rst during WR_PULSE → WE=1 and bus Z the next cycle, no rsp_valid, req_ready=1 after release.
- MEM_RESP_STATS_EN: 3 reads and 2 writes → rd_count=3, wr_count=2. Preload wr_count=0xFFFF, do 1 write → 0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared FSM state encoding and SRAM pin constants for mem_responder.
package mem_responder_pkg;

    typedef enum logic [2:0] {
        MR_IDLE,
        MR_RD,
        MR_WR_SETUP,
        MR_WR_PULSE,
        MR_WR_HOLD
    } mr_state_t;

    localparam logic SRAM_INACTIVE = 1'b1;

endpackage

// File: rtl/mem_responder.sv
// mem_responder: single-request responder driving an asynchronous SRAM bank with registered pins.
// Optional MEM_RESP_STATS_EN adds 16-bit read/write completion counters.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] SramAddr,
    inout  wire  [DATA_W-1:0] SramData,
    output logic              SramOE,
    output logic              SramWE,
    output logic              SramEN
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(WAIT_CYCLES - 1);

    mr_state_t         state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_en;
    logic              done;
    logic              rsp_n;

    assign req_ready = state == MR_IDLE;
    assign done      = cnt == '0;
    assign SramData  = drive_en ? wdata_q : 'z;

    always_comb begin
        state_n = state == MR_IDLE     ? (req_valid ? (req_we ? MR_WR_SETUP : MR_RD) : MR_IDLE)
                : state == MR_RD       ? (done ? MR_IDLE : MR_RD)
                : state == MR_WR_SETUP ? MR_WR_PULSE
                : state == MR_WR_PULSE ? (done ? MR_WR_HOLD : MR_WR_PULSE)
                : MR_IDLE;
        cnt_n   = state_n != state ? LOAD : (done ? cnt : cnt - CW'(1));
        rsp_n   = (state == MR_RD && done) || state == MR_WR_HOLD;
    end

    // Pins are registered from the next state so they change cleanly on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MR_IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            SramAddr  <= '0;
            wdata_q   <= '0;
            drive_en  <= 1'b0;
            SramOE    <= SRAM_INACTIVE;
            SramWE    <= SRAM_INACTIVE;
            SramEN    <= SRAM_INACTIVE;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rsp_valid <= rsp_n;
            if (state == MR_RD && done)
                rsp_rdata <= SramData;
            if (state == MR_IDLE && req_valid) begin
                SramAddr <= req_addr;
                wdata_q  <= req_wdata;
            end
            drive_en <= state_n inside {MR_WR_SETUP, MR_WR_PULSE, MR_WR_HOLD};
            SramOE   <= state_n == MR_RD ? ~SRAM_INACTIVE : SRAM_INACTIVE;
            SramWE   <= state_n == MR_WR_PULSE ? ~SRAM_INACTIVE : SRAM_INACTIVE;
            SramEN   <= state_n == MR_IDLE ? SRAM_INACTIVE : ~SRAM_INACTIVE;
        end
    end

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (state == MR_RD && done)
                rd_count <= rd_count + 16'd1;
            if (state == MR_WR_HOLD)
                wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for two mem_responder instances (WAIT_CYCLES 1 and 3).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [17:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_rdata [2];
    logic [17:0] sram_addr [2];
    logic        oe        [2];
    logic        we        [2];
    logic        en        [2];
    logic        drv       [2];
    logic [15:0] bus_v     [2];
`ifdef MEM_RESP_STATS_EN
    logic [15:0] rd_cnt    [2];
    logic [15:0] wr_cnt    [2];
`endif

    int checks = 0;
    int failures = 0;
    int viol = 0;
    bit mon_on = 0;
    logic [15:0] ref_mem [int];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        wire  [15:0] bus;
        logic [15:0] mem [262144];
        mem_responder #(.WAIT_CYCLES(g == 0 ? 1 : 3), .ADDR_W(18), .DATA_W(16)) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
            .SramAddr(sram_addr[g]), .SramData(bus),
            .SramOE(oe[g]), .SramWE(we[g]), .SramEN(en[g])
`ifdef MEM_RESP_STATS_EN
            , .rd_count(rd_cnt[g]), .wr_count(wr_cnt[g])
`endif
        );
        // Asynchronous SRAM device: drives on OE low, stores while WE low.
        assign bus = (!en[g] && !oe[g]) ? mem[sram_addr[g]] : 16'bz;
        assign bus_v[g] = bus;
        assign drv[g] = dut.drive_en;
        always @(posedge clk)
            if (!en[g] && !we[g])
                mem[sram_addr[g]] <= bus;
    end

    // OE low never coincides with a driven bus or WE low; a deselected chip has everything idle.
    always @(negedge clk)
        if (mon_on)
            for (int d = 0; d < 2; d++)
                if ((!oe[d] && (drv[d] || !we[d])) || (en[d] && (drv[d] || !oe[d] || !we[d])))
                    viol++;

    function automatic int wc(input int d);
        return d == 0 ? 1 : 3;
    endfunction

    function automatic int key(input int d, input logic [17:0] a);
        return d * 262144 + int'(a);
    endfunction

    task automatic wait_ready(input int d);
        int n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready[d]) begin
            failures++;
            $display("FAIL wait_ready[%0d]: req_ready=%0b required 1", d, req_ready[d]);
        end
    endtask

    task automatic issue(input int d, input bit w, input logic [17:0] a, input logic [15:0] wd);
        req_valid[d] = 1'b1;
        req_we[d]    = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
    endtask

    task automatic complete(input int d, input bit w, input logic [17:0] a, input logic [15:0] wd);
        int cyc = 0, oel = 0, wel = 0;
        bit got = 0, pins_ok = 1, busy_ok = 1;
        logic [15:0] prev = rsp_rdata[d];
        logic [15:0] expd = w ? wd : (ref_mem.exists(key(d, a)) ? ref_mem[key(d, a)] : 16'h0);
        int lat = w ? wc(d) + 3 : wc(d) + 1;
        @(posedge clk);
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req_valid[d] = 1'b0;
                req_addr[d]  = $urandom;
                req_wdata[d] = $urandom;
            end
            if (rsp_valid[d]) got = 1;
            else begin
                if (!oe[d]) oel++;
                if (!we[d]) wel++;
                if (req_ready[d]) busy_ok = 0;
                if (sram_addr[d] !== a || en[d] !== 1'b0) pins_ok = 0;
                if (w && (!drv[d] || bus_v[d] !== wd)) pins_ok = 0;
            end
        end
        checks += 6;
        if (!got || cyc != lat) begin
            failures++;
            $display("FAIL latency[%0d] we=%0b: got cycle %0d required %0d", d, w, cyc, lat);
        end
        if (oel != (w ? 0 : wc(d))) begin
            failures++;
            $display("FAIL oe_low[%0d] we=%0b: got %0d cycles required %0d", d, w, oel, w ? 0 : wc(d));
        end
        if (wel != (w ? wc(d) : 0)) begin
            failures++;
            $display("FAIL we_low[%0d] we=%0b: got %0d cycles required %0d", d, w, wel, w ? wc(d) : 0);
        end
        if (!pins_ok || !busy_ok) begin
            failures++;
            $display("FAIL pins[%0d] we=%0b addr=%h: pins_ok=%0b busy_ok=%0b required 1 1", d, w, a, pins_ok, busy_ok);
        end
        if (rsp_rdata[d] !== (w ? prev : expd)) begin
            failures++;
            $display("FAIL rdata[%0d] we=%0b addr=%h: got %h required %h", d, w, a, rsp_rdata[d], w ? prev : expd);
        end
        if (req_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL rsp_ready[%0d]: req_ready=%0b required 1", d, req_ready[d]);
        end
        if (w) ref_mem[key(d, a)] = wd;
    endtask

    task automatic txn(input int d, input bit w, input logic [17:0] a, input logic [15:0] wd);
        wait_ready(d);
        issue(d, w, a, wd);
        complete(d, w, a, wd);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks += 3;
            if ({en[d], oe[d], we[d], drv[d]} !== 4'b1110) begin
                failures++;
                $display("FAIL reset_pins[%0d]: en/oe/we/drv=%b required 1110", d, {en[d], oe[d], we[d], drv[d]});
            end
            if ({rsp_valid[d], req_ready[d]} !== 2'b01) begin
                failures++;
                $display("FAIL reset_hs[%0d]: rsp_valid/req_ready=%b required 01", d, {rsp_valid[d], req_ready[d]});
            end
            if (rsp_rdata[d] !== 16'h0 || sram_addr[d] !== 18'h0) begin
                failures++;
                $display("FAIL reset_data[%0d]: rdata=%h addr=%h required 0 0", d, rsp_rdata[d], sram_addr[d]);
            end
`ifdef MEM_RESP_STATS_EN
            checks++;
            if (rd_cnt[d] !== 16'h0 || wr_cnt[d] !== 16'h0) begin
                failures++;
                $display("FAIL reset_stats[%0d]: rd=%h wr=%h required 0 0", d, rd_cnt[d], wr_cnt[d]);
            end
`endif
        end
        mon_on = 1;
    endtask

    task automatic test_directed();
        txn(0, 1, 18'h00010, 16'h1234);
        txn(0, 0, 18'h00010, 16'h0);
        txn(1, 1, 18'h00010, 16'h1234);
        txn(1, 0, 18'h00010, 16'h0);
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 2; d++) begin
            txn(d, 0, 18'h00010, 16'h0);
            issue(d, 1, 18'h3FFFF, 16'hFFFF);
            complete(d, 1, 18'h3FFFF, 16'hFFFF);
            issue(d, 0, 18'h3FFFF, 16'h0);
            complete(d, 0, 18'h3FFFF, 16'h0);
        end
    endtask

    task automatic test_random();
        logic [17:0] pool [8];
        for (int i = 0; i < 8; i++) pool[i] = 18'($urandom);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++)
                txn(d, 1, pool[i], 16'($urandom));
        for (int n = 0; n < 40; n++) begin
            int d = int'($urandom_range(0, 1));
            bit w = 1'($urandom);
            logic [17:0] a = pool[$urandom_range(0, 7)];
            txn(d, w, a, 16'($urandom));
        end
    endtask

    task automatic test_reset_mid_write();
        for (int d = 0; d < 2; d++) begin
            bit quiet = 1;
            wait_ready(d);
            issue(d, 1, 18'h2AAAA, 16'h5A5A);
            @(posedge clk);
            @(negedge clk);
            req_valid[d] = 1'b0;
            @(negedge clk);
            checks++;
            if (we[d] !== 1'b0) begin
                failures++;
                $display("FAIL pulse_we[%0d]: we=%0b required 0", d, we[d]);
            end
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if ({en[d], oe[d], we[d], drv[d], rsp_valid[d]} !== 5'b11100) begin
                failures++;
                $display("FAIL abort_pins[%0d]: en/oe/we/drv/rsp=%b required 11100", d, {en[d], oe[d], we[d], drv[d], rsp_valid[d]});
            end
            rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (rsp_valid[d] || !req_ready[d]) quiet = 0;
            end
            checks++;
            if (!quiet) begin
                failures++;
                $display("FAIL abort_quiet[%0d]: stray rsp_valid or req_ready low after release", d);
            end
            ref_mem.delete(key(d, 18'h2AAAA));
        end
    endtask

`ifdef MEM_RESP_STATS_EN
    task automatic test_stats();
        logic [15:0] r0 = rd_cnt[0], w0 = wr_cnt[0];
        txn(0, 1, 18'h00100, 16'hBEEF);
        txn(0, 0, 18'h00100, 16'h0);
        txn(0, 1, 18'h00101, 16'hCAFE);
        txn(0, 0, 18'h00101, 16'h0);
        txn(0, 0, 18'h00100, 16'h0);
        checks++;
        if (rd_cnt[0] !== r0 + 16'd3 || wr_cnt[0] !== w0 + 16'd2) begin
            failures++;
            $display("FAIL stats_count: rd+%0d wr+%0d required rd+3 wr+2", rd_cnt[0] - r0, wr_cnt[0] - w0);
        end
        force u[0].dut.wr_count = 16'hFFFF;
        @(negedge clk);
        release u[0].dut.wr_count;
        txn(0, 1, 18'h00102, 16'h0001);
        checks++;
        if (wr_cnt[0] !== 16'h0) begin
            failures++;
            $display("FAIL stats_wrap: wr_count=%h required 0000", wr_cnt[0]);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
`ifdef MEM_RESP_STATS_EN
        test_stats();
`endif
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL pin_rules: %0d cycles violated OE/WE/bus rules, required 0", viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
